// File: rtl/uart_tx_scheduler.sv
// uart_tx_scheduler
//
// Shares one UART transmitter between N byte-stream requesters. A requester
// is granted between messages in round-robin order and keeps the grant until
// it hands over a byte marked last (or, optionally, goes quiet for too long).
// Each accepted byte becomes one single-cycle tx_request strobe to the UART.
//
// state  | meaning
// -------+----------------------------------------------------------------
// IDLE   | no owner; arbitrate among valid requesters starting at ptr
// LOCKED | owner waits for its byte and the UART; lock timeout runs here
// PULSE  | tx_request high for this one cycle, tx_data holds the byte
// GAP    | one dead cycle while the UART drops tx_ready; release if last
//
// Ports
//   clk         single clock
//   reset       synchronous, active-high
//   req_valid   [N]    requester i has a byte on its lane
//   req_data    [8N]   byte lanes, lane i at [8i+7:8i]
//   req_last    [N]    lane i's byte ends its message
//   req_ready   [N]    lane i's byte is accepted this cycle (owner only)
//   grant       [N]    one-hot lock owner, zero when unlocked
//   tx_data     [8]    byte to the UART, held between strobes
//   tx_request         one-cycle strobe to the UART
//   tx_ready           UART idle
//   busy               scheduler is not in IDLE

module uart_tx_scheduler #(
    parameter int N            = 4,
    parameter int LOCK_TIMEOUT = 0
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [N-1:0]   req_valid,
    input  logic [8*N-1:0] req_data,
    input  logic [N-1:0]   req_last,
    output logic [N-1:0]   req_ready,
    output logic [N-1:0]   grant,
    output logic [7:0]     tx_data,
    output logic           tx_request,
    input  logic           tx_ready,
    output logic           busy
);

    localparam int IW = (N < 2) ? 1 : $clog2(N);
    localparam int CW = (LOCK_TIMEOUT < 2) ? 1 : $clog2(LOCK_TIMEOUT + 1);
    // The lock is dropped on the edge that ends the LOCK_TIMEOUT-th quiet cycle,
    // i.e. when the counter already holds LOCK_TIMEOUT-1 and the owner is still quiet.
    localparam logic [CW-1:0] TO_LAST = CW'((LOCK_TIMEOUT > 0) ? LOCK_TIMEOUT - 1 : 0);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LOCKED = 2'd1,
        S_PULSE  = 2'd2,
        S_GAP    = 2'd3
    } state_t;

    state_t          state_q;
    logic [N-1:0]    grant_q;
    logic [IW-1:0]   own_q;
    logic [IW-1:0]   ptr_q;
    logic [7:0]      tx_data_q;
    logic            tx_request_q;
    logic            last_q;
    logic [CW-1:0]   cnt_q;

    logic            pick_valid_d;
    logic [IW-1:0]   pick_idx_d;
    logic [IW-1:0]   ptr_inc_d;
    logic            own_valid_d;
    logic            own_last_d;
    logic [7:0]      own_byte_d;
    logic            timed_out_d;

    // Round-robin pick: walk offsets from high to low so the smallest offset
    // from ptr (the first valid lane at or after ptr) is the one that sticks.
    always_comb begin : pick
        int lane;
        pick_valid_d = 1'b0;
        pick_idx_d   = '0;
        lane         = 0;
        for (int k = N - 1; k >= 0; k--) begin
            lane = int'(ptr_q) + k;
            if (lane >= N) begin
                lane = lane - N;
            end
            if (req_valid[lane]) begin
                pick_valid_d = 1'b1;
                pick_idx_d   = IW'(lane);
            end
        end
    end

    assign own_valid_d = req_valid[own_q];
    assign own_last_d  = req_last[own_q];
    assign own_byte_d  = req_data[{own_q, 3'b000} +: 8];
    assign ptr_inc_d   = (own_q == IW'(N - 1)) ? '0 : own_q + 1'b1;
    assign timed_out_d = (LOCK_TIMEOUT != 0) && (cnt_q == TO_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            grant_q      <= '0;
            own_q        <= '0;
            ptr_q        <= '0;
            tx_data_q    <= 8'h00;
            tx_request_q <= 1'b0;
            last_q       <= 1'b0;
            cnt_q        <= '0;
        end else begin
            tx_request_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (pick_valid_d) begin
                        own_q   <= pick_idx_d;
                        grant_q <= N'(1) << pick_idx_d;
                        cnt_q   <= '0;
                        state_q <= S_LOCKED;
                    end
                end
                S_LOCKED: begin
                    if (own_valid_d) begin
                        cnt_q <= '0;
                        if (tx_ready) begin
                            tx_data_q    <= own_byte_d;
                            last_q       <= own_last_d;
                            tx_request_q <= 1'b1;
                            state_q      <= S_PULSE;
                        end
                    end else if (timed_out_d) begin
                        ptr_q   <= ptr_inc_d;
                        grant_q <= '0;
                        cnt_q   <= '0;
                        state_q <= S_IDLE;
                    end else if (LOCK_TIMEOUT != 0) begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_PULSE: begin
                    state_q <= S_GAP;
                end
                S_GAP: begin
                    // tx_ready is not looked at here: the UART may still be
                    // dropping it in response to the strobe.
                    if (last_q) begin
                        ptr_q   <= ptr_inc_d;
                        grant_q <= '0;
                        state_q <= S_IDLE;
                    end else begin
                        cnt_q   <= '0;
                        state_q <= S_LOCKED;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign req_ready  = (state_q == S_LOCKED && own_valid_d && tx_ready) ? grant_q : '0;
    assign grant      = grant_q;
    assign tx_data    = tx_data_q;
    assign tx_request = tx_request_q;
    assign busy       = (state_q != S_IDLE);

endmodule
